// File: rtl/button_debouncer.sv
// Debounces a raw active-low push-button: a synchronizer chain followed by a
// four-state qualify FSM that accepts a level only after DEBOUNCE_CYCLES matching samples.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Bin,
    output logic Bout,
    output logic Busy
);

    typedef enum logic [1:0] {
        STABLE_HI = 2'b00,
        CHECK_LO  = 2'b01,
        STABLE_LO = 2'b10,
        CHECK_HI  = 2'b11
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   bout_q, bout_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_HI: begin
                if (!s) begin
                    state_d = CHECK_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHECK_LO: begin
                // A sample matching the current level aborts qualification outright.
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_LO: begin
                if (s) begin
                    state_d = CHECK_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            CHECK_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_HI;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        bout_d = (state_d == STABLE_HI) || (state_d == CHECK_LO);
        busy_d = (state_d == CHECK_LO) || (state_d == CHECK_HI);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same edge.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q  <= '1;
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            bout_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], Bin};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
        end
    end

    assign Bout = bout_q;
    assign Busy = busy_q;

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Front-end conditioning stage for a raw, active-low push-button input. It synchronizes the asynchronous pin into the `Clk` domain and rejects contact bounce with a consecutive-sample counter. It outputs a clean active-low level that feeds the single-cycle pulse shaper directly. `Bout` keeps the pin's polarity, so the shaper connects with no inversion.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in the synchronizer chain; legal range is ≥2.
- `DEBOUNCE_CYCLES`, default 250000: consecutive differing samples required to accept a change (5 ms at 50 MHz); legal range is ≥2.
- `CNT_WIDTH`, default 18: counter width; must hold DEBOUNCE_CYCLES−1.
- `Clk`, input, 1: system clock; all logic updates on the rising edge.
- `Rst`, input, 1: reset; synchronous, active-high.
- `Bin`, input, 1: raw button pin, asynchronous, active-low (0 = pressed).
- `Bout`, output, 1: debounced level, active-low (0 = pressed); registered.
- `Busy`, output, 1: high while a candidate change is being qualified (state CHECK_LO or CHECK_HI); registered.

## Operation
- **Synchronizer:** a shift chain of SYNC_STAGES flops clocks `Bin` in. Its last stage is `s`. There is no other use of raw `Bin`.
- **Reset (Rst=1 at an edge)**
  - All synchronizer flops become 1.
  - State becomes STABLE_HI, counter becomes 0, `Bout` becomes 1, `Busy` becomes 0.
  - Reset overrides every other event on that edge.
- **FSM states:** STABLE_HI (Bout=1), CHECK_LO (Bout=1), STABLE_LO (Bout=0), CHECK_HI (Bout=0).
- **STABLE_HI**
  - If s=0: go to CHECK_LO, counter becomes 1.
  - Otherwise: hold, counter stays 0.
- **CHECK_LO**
  - If s=1: go back to STABLE_HI, counter becomes 0. This is glitch rejection, and `Bout` never changes.
  - Else if counter = DEBOUNCE_CYCLES−1: go to STABLE_LO, `Bout` becomes 0, counter becomes 0.
  - Otherwise: counter increments by 1.
- **STABLE_LO / CHECK_HI:** mirror images of the two rules above with 0 and 1 swapped. Accepting the release sets `Bout` to 1.
- **Counter:** unsigned, never exceeds DEBOUNCE_CYCLES−1 and never wraps. It is cleared on every return to a STABLE state.
- **Busy:** equals 1 exactly in the CHECK states, registered alongside the state.
- **Restart on bounce:** any single sample of s that matches the current `Bout` during a CHECK state aborts qualification. The count then restarts from zero.

## Timing
- **Acceptance condition:** `Bout` changes only after DEBOUNCE_CYCLES consecutive samples of s that differ from `Bout`.
- **Press latency:** say `Bin` is held low and first sampled at edge 0. Then:
  - s goes low after edge SYNC_STAGES−1.
  - The FSM enters CHECK_LO at edge SYNC_STAGES.
  - `Bout` goes low after edge SYNC_STAGES+DEBOUNCE_CYCLES−1, which is SYNC_STAGES+DEBOUNCE_CYCLES edges inclusive.
  - `Busy` rises after edge SYNC_STAGES and falls on the same edge `Bout` changes.
- **Release latency:** identical to press latency.
- **Glitch rejection:** pulses on `Bin` shorter than DEBOUNCE_CYCLES samples produce no `Bout` change.
- **Reset with button held:** if `Bin` is held low through reset release, `Bout` falls SYNC_STAGES+DEBOUNCE_CYCLES edges after the first non-reset edge. The press is re-qualified, not assumed.
- **Throughput:** after a completed change, the opposite transition can begin qualifying on the very next sample. There is no dead time.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_WIDTH=2.

- **Reset values:** hold Rst=1 for 3 edges with Bin=0 → Bout=1 and Busy=0 on every edge. Release Rst with Bin still 0 → Bout=0 after the 6th subsequent edge, Busy=1 after edges 3–5.
- **Clean press:** Bin 1→0 sampled at edge 0 and held → Busy=1 after edge 2, Bout=0 after edge 5 (not before), Busy=0 after edge 5.
- **Glitch:** Bin=0 for 3 samples then back to 1 → Bout stays 1 throughout; Busy pulses for 3 cycles then returns to 0.
- **Bounce then settle:** Bin pattern 0,1,0,0,1,0,0,0,0 from edge 0 → counter restarts on each 1; Bout=0 exactly after the 4th consecutive synchronized 0, which is edge 10.
- **Clean release:** after Bout=0 is reached, Bin 0→1 held → Bout=1 after 6 edges, with the same Busy profile as the press.
- **Reset mid-qualification:** assert Rst for 1 edge while in CHECK_LO with counter=2 → Bout=1, Busy=0, counter=0 next cycle. With Bin still 0, a full 6-edge qualification is required afterwards.
